// File: rtl/dbg_cmd_ctrl.sv
// rtl/dbg_cmd_ctrl.sv - UART debug command controller: decodes RX commands, gates pipeline execution
// and requests a status report after every command.
module dbg_cmd_ctrl #(
   parameter int         CNT_W        = 16,
   parameter int         PC_W         = 32,
   parameter int         RUN_TIMEOUT  = 1000000,
   parameter int         RESET_CYCLES = 2,
   parameter logic [7:0] CMD_STEP     = 8'h31,
   parameter logic [7:0] CMD_RUN      = 8'h32,
   parameter logic [7:0] CMD_SWRST    = 8'h33,
   parameter logic [7:0] CMD_STEPN    = 8'h34,
   parameter logic [7:0] CMD_SETBP    = 8'h35,
   parameter logic [7:0] CMD_CLRBP    = 8'h36
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       r_data,
   input  logic             rx_ready,
   input  logic [PC_W-1:0]  pc,
   input  logic             program_finished,
   input  logic             send_done,
   output logic             rd_uart,
   output logic             send_req,
   output logic [2:0]       report_code,
   output logic [CNT_W-1:0] cycle_count,
   output logic             pipe_clk_en,
   output logic             pipe_reset,
   output logic             clear_program_finished,
   output logic             bp_valid,
   output logic [2:0]       current_state
);
   localparam int CNT_BYTES = (CNT_W + 7) / 8;
   localparam int PC_BYTES  = (PC_W + 7) / 8;
   localparam int ARG_BYTES = (CNT_BYTES > PC_BYTES) ? CNT_BYTES : PC_BYTES;
   localparam int ARG_W     = 8 * ARG_BYTES;
   localparam int IDX_W     = $clog2(ARG_BYTES + 1);
   localparam int TMO_W     = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT + 1) : 1;
   localparam int RST_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
   localparam logic [IDX_W-1:0] CNT_LAST_IDX = IDX_W'(CNT_BYTES - 1);
   localparam logic [IDX_W-1:0] PC_LAST_IDX  = IDX_W'(PC_BYTES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(RUN_TIMEOUT - 1);
   localparam logic [RST_W-1:0] RST_LAST     = RST_W'(RESET_CYCLES - 1);

   typedef enum logic [2:0] {
      S_INIT = 3'd0, S_WAIT = 3'd1, S_ARG = 3'd2, S_STEP = 3'd3,
      S_RUN = 3'd4, S_SWRST = 3'd5, S_REPORT = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic               rd_q, rd_d;
   logic [2:0]         code_q, code_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, n_q, n_d, go_n;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [RST_W-1:0]   rst_q, rst_d;
   logic [7:0]         cmd_q, cmd_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [ARG_W-1:0]   arg_q, arg_d, arg_full;
   logic [PC_W-1:0]    bp_q, bp_d;
   logic               bp_valid_q, bp_valid_d;
   logic               accept, step_go, run_go;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_INIT;
         rd_q       <= 1'b0;
         code_q     <= '0;
         cnt_q      <= '0;
         n_q        <= '0;
         tmo_q      <= '0;
         rst_q      <= '0;
         cmd_q      <= '0;
         idx_q      <= '0;
         arg_q      <= '0;
         bp_q       <= '0;
         bp_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         code_q     <= code_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         tmo_q      <= tmo_d;
         rst_q      <= rst_d;
         cmd_q      <= cmd_d;
         idx_q      <= idx_d;
         arg_q      <= arg_d;
         bp_q       <= bp_d;
         bp_valid_q <= bp_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rd_d       = 1'b0;
      code_d     = code_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      tmo_d      = tmo_q;
      rst_d      = rst_q;
      cmd_d      = cmd_q;
      idx_d      = idx_q;
      arg_d      = arg_q;
      bp_d       = bp_q;
      bp_valid_d = bp_valid_q;
      step_go    = 1'b0;
      run_go     = 1'b0;
      go_n       = CNT_W'(1);
      // The rd_uart cycle masks rx_ready so the byte being popped is not taken twice.
      accept     = (state_q == S_WAIT || state_q == S_ARG) && rx_ready && !rd_q;
      arg_full   = arg_q;
      for (int b = 0; b < ARG_BYTES; b++) begin
         if (idx_q == IDX_W'(b)) arg_full[8*b +: 8] = r_data;
      end

      case (state_q)
         S_INIT: state_d = S_WAIT;
         S_WAIT: begin
            if (accept) begin
               rd_d = 1'b1;
               if (r_data == CMD_STEP) step_go = 1'b1;
               else if (r_data == CMD_RUN) run_go = 1'b1;
               else if (r_data == CMD_SWRST) begin
                  state_d = S_SWRST;
                  rst_d   = '0;
               end else if (r_data == CMD_STEPN || r_data == CMD_SETBP) begin
                  state_d = S_ARG;
                  cmd_d   = r_data;
                  idx_d   = '0;
                  arg_d   = '0;
               end else if (r_data == CMD_CLRBP) begin
                  bp_valid_d = 1'b0;
                  code_d     = 3'd7;
                  state_d    = S_REPORT;
               end else begin
                  code_d  = 3'd5;
                  state_d = S_REPORT;
               end
            end
         end
         S_ARG: begin
            if (accept) begin
               rd_d  = 1'b1;
               arg_d = arg_full;
               idx_d = idx_q + IDX_W'(1);
               if (cmd_q == CMD_STEPN) begin
                  if (idx_q == CNT_LAST_IDX) begin
                     step_go = 1'b1;
                     go_n    = arg_full[CNT_W-1:0];
                  end
               end else if (idx_q == PC_LAST_IDX) begin
                  bp_d       = arg_full[PC_W-1:0];
                  bp_valid_d = 1'b1;
                  code_d     = 3'd6;
                  state_d    = S_REPORT;
               end
            end
         end
         S_STEP, S_RUN: begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            tmo_d = tmo_q + TMO_W'(1);
            // A zero count skips the breakpoint so execution can resume from it.
            if (program_finished) begin
               code_d  = 3'd1;
               state_d = S_REPORT;
            end else if (bp_valid_q && pc == bp_q && cnt_q != '0) begin
               code_d  = 3'd2;
               state_d = S_REPORT;
            end else if (state_q == S_STEP && cnt_q + CNT_W'(1) == n_q) begin
               code_d  = 3'd0;
               state_d = S_REPORT;
            end else if (state_q == S_RUN && RUN_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
               code_d  = 3'd3;
               state_d = S_REPORT;
            end
         end
         S_SWRST: begin
            if (rst_q == RST_LAST) begin
               code_d  = 3'd4;
               state_d = S_REPORT;
            end else begin
               rst_d = rst_q + RST_W'(1);
            end
         end
         S_REPORT: if (send_done) state_d = S_WAIT;
         default:  state_d = S_INIT;
      endcase

      if (step_go || run_go) begin
         cnt_d = '0;
         tmo_d = '0;
         n_d   = go_n;
         if (program_finished) begin
            code_d  = 3'd1;
            state_d = S_REPORT;
         end else if (step_go && go_n == '0) begin
            code_d  = 3'd0;
            state_d = S_REPORT;
         end else begin
            state_d = step_go ? S_STEP : S_RUN;
         end
      end
   end

   always_comb begin
      pipe_clk_en            = 1'b0;
      pipe_reset             = 1'b0;
      clear_program_finished = 1'b0;
      send_req               = 1'b0;
      case (state_q)
         S_INIT, S_SWRST: begin
            pipe_clk_en            = 1'b1;
            pipe_reset             = 1'b1;
            clear_program_finished = 1'b1;
         end
         S_STEP, S_RUN: pipe_clk_en = 1'b1;
         S_REPORT:      send_req    = 1'b1;
         default:       ;
      endcase
   end

   assign rd_uart       = rd_q;
   assign report_code   = code_q;
   assign cycle_count   = cnt_q;
   assign bp_valid      = bp_valid_q;
   assign current_state = state_q;

endmodule

// File: tb/tb_dbg_cmd_ctrl.sv
// tb/tb_dbg_cmd_ctrl.sv - table-driven bench for dbg_cmd_ctrl with a small pipeline/PC model.
module tb_dbg_cmd_ctrl;
   localparam int CNT_W = 16;
   localparam int PC_W  = 32;

   logic             clock = 1'b0;
   logic             reset;
   logic [7:0]       r_data;
   logic             rx_ready;
   logic [PC_W-1:0]  pc;
   logic             program_finished;
   logic             send_done;
   logic             rd_uart;
   logic             send_req;
   logic [2:0]       report_code;
   logic [CNT_W-1:0] cycle_count;
   logic             pipe_clk_en;
   logic             pipe_reset;
   logic             clear_program_finished;
   logic             bp_valid;
   logic [2:0]       current_state;

   dbg_cmd_ctrl #(
      .CNT_W(CNT_W), .PC_W(PC_W), .RUN_TIMEOUT(20), .RESET_CYCLES(2)
   ) dut (
      .clock(clock), .reset(reset), .r_data(r_data), .rx_ready(rx_ready), .pc(pc),
      .program_finished(program_finished), .send_done(send_done), .rd_uart(rd_uart),
      .send_req(send_req), .report_code(report_code), .cycle_count(cycle_count),
      .pipe_clk_en(pipe_clk_en), .pipe_reset(pipe_reset),
      .clear_program_finished(clear_program_finished), .bp_valid(bp_valid),
      .current_state(current_state)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [39:0] bytes;
      int          nb;
      logic        pf0;
      int          pf_after;
      logic        set_pc;
      logic [31:0] pc0;
      logic [2:0]  code;
      int          cnt;
      int          en;
      int          rd;
      int          prst;
      logic        bpv;
   } vec_t;

   int n_applied = 0;
   int n_fail    = 0;
   int en_cycles, rd_pulses, prst_cycles, pf_after;
   vec_t vecs[16];

   function automatic vec_t mk(input logic [39:0] bytes, input int nb, input logic pf0,
                               input int pfa, input logic set_pc, input logic [31:0] pc0,
                               input logic [2:0] code, input int cnt, input int en,
                               input int prst, input logic bpv);
      vec_t v;
      v.bytes = bytes; v.nb = nb; v.pf0 = pf0; v.pf_after = pfa; v.set_pc = set_pc;
      v.pc0 = pc0; v.code = code; v.cnt = cnt; v.en = en; v.rd = nb; v.prst = prst; v.bpv = bpv;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock; the pipeline model advances pc on every edge that was clock-enabled.
   task automatic cyc();
      logic en_before, prst_before;
      en_before   = pipe_clk_en;
      prst_before = pipe_reset;
      @(posedge clock);
      #1;
      if (en_before) begin
         pc = pc + 32'd4;
         en_cycles++;
         if (en_cycles == pf_after) program_finished = 1'b1;
      end
      if (prst_before) prst_cycles++;
      if (rd_uart) rd_pulses++;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      r_data   = b;
      rx_ready = 1'b1;
      n = 0;
      while (!rd_uart && n < 50) begin
         cyc();
         n++;
      end
      if (!rd_uart) begin
         n_applied++;
         n_fail++;
         $display("FAIL rx_accept: byte %0h never popped", b);
      end
      rx_ready = 1'b0;
      cyc();
   endtask

   task automatic wait_report(input string name);
      int n;
      n = 0;
      while (!send_req && n < 400) begin
         cyc();
         n++;
      end
      check({name, " send_req"}, {31'd0, send_req}, 32'd1);
   endtask

   task automatic finish_report(input string name);
      send_done = 1'b1;
      cyc();
      send_done = 1'b0;
      check({name, " req_drop"}, {31'd0, send_req}, 32'd0);
      check({name, " to_wait"}, {29'd0, current_state}, 32'd1);
   endtask

   initial begin
      logic [39:0] bb;
      reset = 1'b1; r_data = '0; rx_ready = 1'b0; pc = 32'h0040_0000;
      program_finished = 1'b0; send_done = 1'b0; pf_after = -1;
      en_cycles = 0; rd_pulses = 0; prst_cycles = 0;

      //            bytes           nb pf pfa set pc0           code cnt  en  prst bpv
      vecs[0]  = mk(40'h31,          1, 0, -1, 0, 32'h0,        0,   1,   1,  0,  0);
      vecs[1]  = mk(40'h00_05_34,    3, 0, -1, 0, 32'h0,        0,   5,   5,  0,  0);
      vecs[2]  = mk(40'h00_40_00_10_35, 5, 0, -1, 0, 32'h0,     6,   5,   0,  0,  1);
      vecs[3]  = mk(40'h32,          1, 0, -1, 1, 32'h003F_FFF8, 2,  7,   7,  0,  1);
      vecs[4]  = mk(40'h32,          1, 0, -1, 1, 32'h0040_0010, 3, 20,  20,  0,  1);
      vecs[5]  = mk(40'h36,          1, 0, -1, 0, 32'h0,        7,  20,   0,  0,  0);
      vecs[6]  = mk(40'h32,          1, 0, -1, 1, 32'h003F_FFF8, 3, 20,  20,  0,  0);
      vecs[7]  = mk(40'h32,          1, 1, -1, 0, 32'h0,        1,   0,   0,  0,  0);
      vecs[8]  = mk(40'h31,          1, 1, -1, 0, 32'h0,        1,   0,   0,  0,  0);
      vecs[9]  = mk(40'h00_00_34,    3, 0, -1, 0, 32'h0,        0,   0,   0,  0,  0);
      vecs[10] = mk(40'h00_40_00_08_35, 5, 0, -1, 0, 32'h0,     6,   0,   0,  0,  1);
      vecs[11] = mk(40'h33,          1, 0, -1, 0, 32'h0,        4,   0,   2,  2,  1);
      vecs[12] = mk(40'h00_0A_34,    3, 0, -1, 1, 32'h0040_0000, 2,  3,   3,  0,  1);
      vecs[13] = mk(40'h00_0A_34,    3, 0,  3, 1, 32'h0050_0000, 1,  4,   4,  0,  1);
      vecs[14] = mk(40'h7A,          1, 0, -1, 0, 32'h0,        5,   4,   0,  0,  1);
      vecs[15] = mk(40'h01_03_34,    3, 0, -1, 1, 32'h0050_0000, 0, 259, 259, 0,  1);

      // Reset state and INIT -> WAIT
      @(posedge clock); #1;
      @(posedge clock); #1;
      check("rst state", {29'd0, current_state}, 32'd0);
      check("rst ctrl", {29'd0, pipe_clk_en, pipe_reset, clear_program_finished}, 32'd7);
      check("rst outs", {28'd0, send_req, rd_uart, bp_valid, |report_code}, 32'd0);
      check("rst cnt", {16'd0, cycle_count}, 32'd0);
      reset = 1'b0;
      cyc();
      check("init->wait", {29'd0, current_state}, 32'd1);
      check("wait ctrl", {29'd0, pipe_clk_en, pipe_reset, clear_program_finished}, 32'd0);

      // STEP timing: one enabled cycle, rd_uart alongside it, then REPORT
      r_data = 8'h31; rx_ready = 1'b1;
      cyc();
      rx_ready = 1'b0;
      check("step state", {29'd0, current_state}, 32'd3);
      check("step en", {30'd0, pipe_clk_en, rd_uart}, 32'd3);
      cyc();
      check("step report", {29'd0, current_state}, 32'd6);
      check("step en_off", {30'd0, pipe_clk_en, rd_uart}, 32'd0);
      check("step code", {29'd0, report_code}, 32'd0);
      check("step cnt", {16'd0, cycle_count}, 32'd1);

      // send_done and a new byte in the same REPORT cycle: WAIT first, accept next
      r_data = 8'h7A; rx_ready = 1'b1; send_done = 1'b1;
      cyc();
      send_done = 1'b0;
      check("done+rx wait", {29'd0, current_state}, 32'd1);
      check("done+rx no_rd", {31'd0, rd_uart}, 32'd0);
      cyc();
      rx_ready = 1'b0;
      check("done+rx rd", {31'd0, rd_uart}, 32'd1);
      check("done+rx code", {29'd0, report_code}, 32'd5);
      finish_report("done+rx");

      for (int i = 0; i < 16; i++) begin
         string nm;
         nm = $sformatf("v%0d", i);
         program_finished = vecs[i].pf0;
         pf_after = vecs[i].pf_after;
         if (vecs[i].set_pc) pc = vecs[i].pc0;
         en_cycles = 0; rd_pulses = 0; prst_cycles = 0;
         bb = vecs[i].bytes;
         for (int b = 0; b < vecs[i].nb; b++) begin
            send_byte(bb[7:0]);
            bb = bb >> 8;
         end
         wait_report(nm);
         check({nm, " code"}, {29'd0, report_code}, {29'd0, vecs[i].code});
         check({nm, " cnt"}, {16'd0, cycle_count}, vecs[i].cnt);
         check({nm, " en"}, en_cycles, vecs[i].en);
         check({nm, " rd"}, rd_pulses, vecs[i].rd);
         check({nm, " prst"}, prst_cycles, vecs[i].prst);
         check({nm, " bpv"}, {31'd0, bp_valid}, {31'd0, vecs[i].bpv});
         finish_report(nm);
         pf_after = -1;
         program_finished = 1'b0;
      end

      // Reset in the middle of STEPN after 3 enabled cycles
      en_cycles = 0;
      send_byte(8'h34); send_byte(8'h10); send_byte(8'h00);
      for (int n = 0; n < 20 && en_cycles < 3; n++) cyc();
      check("mid en", en_cycles, 3);
      reset = 1'b1;
      cyc();
      check("mid state", {29'd0, current_state}, 32'd0);
      check("mid outs", {29'd0, bp_valid, send_req, rd_uart}, 32'd0);
      check("mid prst", {31'd0, pipe_reset}, 32'd1);
      reset = 1'b0;
      rd_pulses = 0;
      repeat (5) cyc();
      check("mid no_rd", rd_pulses, 0);
      check("mid wait", {29'd0, current_state}, 32'd1);
      check("mid no_req", {31'd0, send_req}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
      $finish;
   end
endmodule
